// File: rtl/wb_pkg.sv
// Shared types and the address decoder for the multi-channel Wishbone master.
package wb_pkg;

  localparam int WB_DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } wb_state_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } decode_t;

  // Splits a byte address into {in-window hit, slave index}. The window is
  // every address whose bits above the index field match the base address;
  // an index at or beyond the slave count is treated as a miss.
  function automatic decode_t region_decode(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input int          region_bits,
                                            input int          n_slaves);
    decode_t d;
    int      idx_w;
    int      idx_v;
    idx_w = (n_slaves > 2) ? $clog2(n_slaves) : 1;
    d.hit = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if ((i >= region_bits + idx_w) && (addr[i] != base[i])) d.hit = 1'b0;
    end
    idx_v = int'((addr >> region_bits) & ((32'd1 << idx_w) - 32'd1));
    d.idx = idx_v[3:0];
    d.hit = d.hit && (idx_v < n_slaves);
    return d;
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Per-access wait counter with terminal-count flag, plus a saturating
// count of how many accesses have been aborted by timeout.
module wb_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       evt,
  output logic       tc,
  output logic [7:0] evt_cnt
);

  logic [7:0] cnt;

  // Wait counter: cleared while idle, counts every strobe cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= 8'd0;
    else if (clr) cnt <= 8'd0;
    else if (en && (cnt != 8'hFF)) cnt <= cnt + 8'd1;
  end

  // The flag marks the last permitted strobe cycle, so the access is cut
  // off after exactly LIMIT strobe cycles.
  assign tc = (cnt == 8'(LIMIT - 1));

  // Timeout event counter, sticks at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) evt_cnt <= 8'd0;
    else if (evt && (evt_cnt != 8'hFF)) evt_cnt <= evt_cnt + 8'd1;
  end

endmodule

// File: rtl/wb_master_nch.sv
// Wishbone classic master: one registered bus cycle per core request,
// routed to one of N_SLAVES equal address regions by a one-hot CYC.
module wb_master_nch
  import wb_pkg::*;
#(
  parameter int          N_SLAVES    = 4,
  parameter int          ADR_W       = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          REGION_BITS = 16,
  parameter int          TIMEOUT     = 255,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      mem_req_i,
  input  logic [3:0]                mem_we_i,
  input  logic [31:0]               mem_addr_i,
  input  logic [31:0]               mem_data_i,
  output logic [31:0]               mem_data_o,
  output logic                      mem_valid_o,
  output logic                      mem_err_o,
  output logic                      mem_busy_o,
  output logic [ADR_W-1:0]          wb_adr_o,
  output logic [31:0]               wb_dat_o,
  output logic                      wb_we_o,
  output logic [3:0]                wb_sel_o,
  output logic                      wb_stb_o,
  output logic [N_SLAVES-1:0]       slv_cyc_o,
  input  logic [N_SLAVES-1:0]       slv_ack_i,
  input  logic [WB_DW*N_SLAVES-1:0] slv_dat_i,
  output logic [7:0]                timeout_cnt_o
);

  wb_state_t             state, state_nxt;
  decode_t               dec;
  logic [3:0]            idx_q, idx_nxt;
  logic                  ack_sel, tc, to_evt;
  logic [WB_DW-1:0]      rd_sel;
  logic [ADR_W-1:0]      adr_nxt;
  logic [31:0]           dat_nxt, data_nxt;
  logic                  we_nxt, stb_nxt, valid_nxt, err_nxt;
  logic [3:0]            sel_nxt;
  logic [N_SLAVES-1:0]   cyc_nxt;

  assign dec        = region_decode(mem_addr_i, BASE_ADDR, REGION_BITS, N_SLAVES);
  assign mem_busy_o = (state != IDLE);

  // Select the addressed slave's ack and read data; other slaves are ignored.
  always_comb begin
    ack_sel = 1'b0;
    rd_sel  = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (idx_q == 4'(k)) begin
        ack_sel = slv_ack_i[k];
        rd_sel  = slv_dat_i[k*WB_DW +: WB_DW];
      end
    end
  end

  wb_timeout_counter #(.LIMIT(TIMEOUT)) u_timeout (
    .clk     (clk_i),
    .rst     (rst_i),
    .clr     (state == IDLE),
    .en      (state == ACCESS),
    .evt     (to_evt),
    .tc      (tc),
    .evt_cnt (timeout_cnt_o)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; an ack on the terminal cycle counts as success.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_req_i) state_nxt = dec.hit ? ACCESS : RESP;
      ACCESS:  if (ack_sel || tc) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered bus and completion outputs.
  always_comb begin
    adr_nxt   = wb_adr_o;
    dat_nxt   = wb_dat_o;
    we_nxt    = wb_we_o;
    sel_nxt   = wb_sel_o;
    idx_nxt   = idx_q;
    cyc_nxt   = slv_cyc_o;
    stb_nxt   = wb_stb_o;
    valid_nxt = 1'b0;
    err_nxt   = mem_err_o;
    data_nxt  = mem_data_o;
    to_evt    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req_i) begin
          adr_nxt = mem_addr_i[ADR_W-1:0];
          dat_nxt = mem_data_i;
          we_nxt  = |mem_we_i;
          sel_nxt = (|mem_we_i) ? mem_we_i : 4'hF;
          idx_nxt = dec.idx;
          if (dec.hit) begin
            for (int k = 0; k < N_SLAVES; k++) cyc_nxt[k] = (dec.idx == 4'(k));
            stb_nxt = 1'b1;
          end else begin
            valid_nxt = 1'b1;
            err_nxt   = 1'b1;
            data_nxt  = ERR_DATA;
          end
        end
      end
      ACCESS: begin
        if (ack_sel) begin
          cyc_nxt   = '0;
          stb_nxt   = 1'b0;
          valid_nxt = 1'b1;
          err_nxt   = 1'b0;
          data_nxt  = wb_we_o ? 32'd0 : rd_sel;
        end else if (tc) begin
          cyc_nxt   = '0;
          stb_nxt   = 1'b0;
          valid_nxt = 1'b1;
          err_nxt   = 1'b1;
          data_nxt  = ERR_DATA;
          to_evt    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output registers; reset clears every output, aborting any bus cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_we_o     <= 1'b0;
      wb_sel_o    <= 4'h0;
      idx_q       <= 4'h0;
      slv_cyc_o   <= '0;
      wb_stb_o    <= 1'b0;
      mem_valid_o <= 1'b0;
      mem_err_o   <= 1'b0;
      mem_data_o  <= '0;
    end else begin
      wb_adr_o    <= adr_nxt;
      wb_dat_o    <= dat_nxt;
      wb_we_o     <= we_nxt;
      wb_sel_o    <= sel_nxt;
      idx_q       <= idx_nxt;
      slv_cyc_o   <= cyc_nxt;
      wb_stb_o    <= stb_nxt;
      mem_valid_o <= valid_nxt;
      mem_err_o   <= err_nxt;
      mem_data_o  <= data_nxt;
    end
  end

endmodule

// File: doc/wb_master_nch.md
Name: wb_master_nch

Overview:
- Parametrised Wishbone classic master bridging the RV32 core's memory-mapped peripheral port to N slave channels: UART, SPI, VGA and future blocks.
- Decodes the address into one of N equal-size regions and runs one registered Wishbone cycle on the shared bus, asserting only that slave's CYC.
- Adds request/valid handshaking, unmapped-address errors, a per-access ack timeout and a saturating timeout counter. The previous master had none of these.
- Sits between the core load/store unit and the peripheral slaves inside the peripheral datapath.

Parameters:
- N_SLAVES, 4, number of slave channels (1..16).
- ADR_W, 16, width of wb_adr_o.
- BASE_ADDR, 32'h8000_0000, base of the peripheral window.
- REGION_BITS, 16, log2 of bytes per slave region (64 KiB each).
- TIMEOUT, 255, cycles to wait for ack before aborting (1..255).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on error.

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- mem_req_i  in  1  request strobe, sampled only in IDLE.
- mem_we_i  in  4  byte write enables; 0 = read.
- mem_addr_i  in  32  byte address.
- mem_data_i  in  32  write data.
- mem_data_o  out  32  read data, valid with mem_valid_o.
- mem_valid_o  out  1  one-cycle completion pulse.
- mem_err_o  out  1  completion was unmapped or timed out; qualified by mem_valid_o.
- mem_busy_o  out  1  high when FSM is not in IDLE.
- wb_adr_o  out  ADR_W  latched mem_addr_i[ADR_W-1:0].
- wb_dat_o  out  32  latched write data.
- wb_we_o  out  1  high if latched mem_we_i != 0.
- wb_sel_o  out  4  latched mem_we_i for writes; 4'hF for reads.
- wb_stb_o  out  1  strobe, shared by all slaves.
- slv_cyc_o  out  N_SLAVES  one-hot per-slave CYC.
- slv_ack_i  in  N_SLAVES  per-slave ACK.
- slv_dat_i  in  32*N_SLAVES  slave k read data at bits [32k+31:32k].
- timeout_cnt_o  out  8  saturating count of timeouts since reset.

Behaviour:
- Reset (async, rst_i=1):
  - FSM goes to IDLE.
  - All outputs become 0, including slv_cyc_o, wb_stb_o, mem_valid_o, mem_err_o, mem_busy_o, mem_data_o and timeout_cnt_o.
  - Reset mid-access drops CYC/STB immediately; no completion pulse is produced.
- Decode:
  - IDX_W = max(1, clog2(N_SLAVES)).
  - Mapped means mem_addr_i[31:REGION_BITS+IDX_W] equals the same bits of BASE_ADDR, and idx = mem_addr_i[REGION_BITS +: IDX_W] < N_SLAVES.
  - Anything else is unmapped.
- FSM states IDLE, ACCESS, RESP.
- IDLE:
  - On mem_req_i=1, latch address, data, we/sel and idx.
  - Mapped: go to ACCESS. slv_cyc_o[idx] and wb_stb_o are high from the next cycle; wait counter is cleared.
  - Unmapped: go to RESP with err=1 and data=ERR_DATA; no bus cycle is started.
- ACCESS:
  - CYC/STB are held stable; the wait counter increments each cycle.
  - slv_ack_i[idx]=1: capture slv_dat_i[idx] for reads (writes return 0), err=0, deassert CYC/STB next cycle, go to RESP.
  - Counter reaches TIMEOUT with no ack: deassert CYC/STB, err=1, data=ERR_DATA, timeout_cnt_o++ (saturates at 255), go to RESP.
  - Ack on the same cycle as the timeout limit: ack wins.
  - Acks from unselected slaves are ignored in every state.
- RESP:
  - mem_valid_o=1 for exactly one cycle, with mem_data_o and mem_err_o registered.
  - Return to IDLE. mem_data_o holds its value until the next completion.
- Handshake and latency:
  - mem_req_i while busy is ignored. The requester must wait for mem_valid_o; back-to-back requests are accepted in the cycle after RESP.
  - Mapped access with ack in the first STB cycle: request at cycle 0, STB at cycle 1, mem_valid_o at cycle 2. Each wait cycle adds 1.
  - Unmapped access: mem_valid_o at cycle 1.
  - A timeout occurs after TIMEOUT STB cycles.
- All outputs are registered; there is no combinational path from slv_ack_i to mem_*.

Decomposition:
- Package wb_pkg:
  - typedef wb_state_t {IDLE, ACCESS, RESP}.
  - constant WB_DW = 32.
  - Function region_decode(addr) returning {hit, idx}.
- One natural sub-module: wb_timeout_counter, an enable/clear counter with a terminal-count flag plus the saturating event counter.
- Slave data mux stays inline.

Test Plan:
- Read slave 2 at 32'h8002_0004; slave 2 acks in its first STB cycle with 32'h1234_5678 -> STB seen on cycle 1 with slv_cyc_o=4'b0100, wb_adr_o=16'h0004, wb_sel_o=4'hF; mem_valid_o at cycle 2 with data 32'h1234_5678, err=0.
- Write mem_we_i=4'b0011, data 32'hAABB_CCDD to 32'h8000_0010; slave 0 acks after 3 wait cycles -> wb_we_o=1, wb_sel_o=4'b0011, wb_dat_o=32'hAABB_CCDD; valid 5 cycles after request; err=0.
- Read 32'h9000_0000, then 32'h8004_0000 with N_SLAVES=4 -> no CYC asserted; valid at cycle 1 with err=1 and data 32'hDEAD_BEEF for both.
- Read slave 1 that never acks, TIMEOUT=8 -> CYC/STB high for 8 cycles then low; err=1, data DEAD_BEEF; timeout_cnt_o=1. Repeat 300 times -> timeout_cnt_o saturates at 255.
- During an access to slave 3: pulse slv_ack_i[0] (ignored); pulse mem_req_i again (ignored); then assert rst_i mid-ACCESS -> all outputs 0 asynchronously, no mem_valid_o, and the next request completes normally.
